// File: rtl/frame_burst_reader_if.sv
// Memory-controller read port, frame request handshake and FIFO write port of the burst reader.
interface frame_burst_reader_if #(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 23,
  parameter int BURST_BITS    = 10
);
  logic                     rd_burst_req;
  logic [BURST_BITS-1:0]    rd_burst_len;
  logic [ADDR_BITS-1:0]     rd_burst_addr;
  logic                     rd_burst_data_valid;
  logic [MEM_DATA_BITS-1:0] rd_burst_data;
  logic                     rd_burst_finish;
  logic                     read_req;
  logic                     read_req_ack;
  logic                     read_finish;
  logic [ADDR_BITS-1:0]     read_addr;
  logic [ADDR_BITS-1:0]     read_len;
  logic [8:0]               wrusedw;
  logic                     fifo_aclr;
  logic                     fifo_wr_en;
  logic [MEM_DATA_BITS-1:0] fifo_wdata;
  logic                     burst_len_err;
  logic [ADDR_BITS-1:0]     last_rd_addr;
  logic [3:0]               read_state;

  modport master (
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    input  read_req, read_addr, read_len, wrusedw,
    output read_req_ack, read_finish,
    output fifo_aclr, fifo_wr_en, fifo_wdata,
    output burst_len_err, last_rd_addr, read_state
  );

  modport slave (
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    output read_req, read_addr, read_len, wrusedw,
    input  read_req_ack, read_finish,
    input  fifo_aclr, fifo_wr_en, fifo_wdata,
    input  burst_len_err, last_rd_addr, read_state
  );
endinterface

// File: rtl/frame_burst_reader.sv
// Read-side burst engine: latches a frame request, issues fixed-size controller bursts while the
// frame FIFO has room for a whole burst, and registers returned beats into the FIFO (1-cycle latency).
module frame_burst_reader #(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 23,
  parameter int BURST_BITS    = 10,
  parameter int BURST_LEN     = 64,
  parameter int ADDR_STEP     = 4096,
  parameter int SPACE_TH      = 192
) (
  input logic                  mem_clk,
  input logic                  rst,
  frame_burst_reader_if.master bus
);

  localparam logic [3:0] S_IDLE           = 4'd0;
  localparam logic [3:0] S_ACK            = 4'd1;
  localparam logic [3:0] S_CHECK_FIFO     = 4'd2;
  localparam logic [3:0] S_READ_BURST     = 4'd3;
  localparam logic [3:0] S_READ_BURST_END = 4'd4;
  localparam logic [3:0] S_END            = 4'd5;

  localparam logic [BURST_BITS-1:0] BURST_LEN_V = BURST_BITS'(BURST_LEN);
  localparam logic [ADDR_BITS-1:0]  STEP_V      = ADDR_BITS'(ADDR_STEP);
  localparam logic [8:0]            SPACE_TH_V  = 9'(SPACE_TH);

  logic [3:0]               state;
  logic [2:0]               req_sync;
  logic                     req_d2;
  logic [ADDR_BITS-1:0]     len_d0;
  logic [ADDR_BITS-1:0]     len_d1;
  logic [ADDR_BITS-1:0]     len_latch;
  logic [ADDR_BITS-1:0]     read_cnt;
  logic [BURST_BITS-1:0]    beat_cnt;
  logic [BURST_BITS-1:0]    beat_next;

  logic                     rd_burst_req;
  logic [BURST_BITS-1:0]    rd_burst_len;
  logic [ADDR_BITS-1:0]     rd_burst_addr;
  logic                     read_req_ack;
  logic                     fifo_aclr;
  logic                     fifo_wr_en;
  logic [MEM_DATA_BITS-1:0] fifo_wdata;
  logic                     burst_len_err;
  logic [ADDR_BITS-1:0]     last_rd_addr;

  assign req_d2 = req_sync[2];
  // A beat arriving together with finish still belongs to the burst being closed.
  assign beat_next = beat_cnt + BURST_BITS'(bus.rd_burst_data_valid);

  // read_req comes from another clock domain; read_len is quasi-static and needs fewer stages.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      req_sync <= '0;
      len_d0   <= '0;
      len_d1   <= '0;
    end else begin
      req_sync <= {req_sync[1:0], bus.read_req};
      len_d0   <= bus.read_len;
      len_d1   <= len_d0;
    end
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      rd_burst_req  <= 1'b0;
      rd_burst_len  <= '0;
      rd_burst_addr <= '0;
      read_req_ack  <= 1'b0;
      fifo_aclr     <= 1'b0;
      burst_len_err <= 1'b0;
      last_rd_addr  <= '0;
      len_latch     <= '0;
      read_cnt      <= '0;
      beat_cnt      <= '0;
    end else begin
      burst_len_err <= 1'b0;
      case (state)
        S_IDLE: begin
          read_req_ack <= 1'b0;
          if (req_d2) state <= S_ACK;
        end
        S_ACK: begin
          read_cnt <= '0;
          if (req_d2) begin
            read_req_ack  <= 1'b1;
            fifo_aclr     <= 1'b1;
            rd_burst_addr <= bus.read_addr;
            len_latch     <= len_d1;
          end else begin
            read_req_ack <= 1'b0;
            fifo_aclr    <= 1'b0;
            state        <= S_CHECK_FIFO;
          end
        end
        S_CHECK_FIFO: begin
          if (req_d2) begin
            state <= S_ACK;
          end else if (read_cnt >= len_latch) begin
            state <= S_END;
          end else if (bus.wrusedw < SPACE_TH_V) begin
            rd_burst_req <= 1'b1;
            rd_burst_len <= BURST_LEN_V;
            beat_cnt     <= '0;
            state        <= S_READ_BURST;
          end
        end
        S_READ_BURST: begin
          beat_cnt <= beat_next;
          // The controller cannot abandon a burst, so a new request waits for finish.
          if (bus.rd_burst_finish) begin
            rd_burst_req  <= 1'b0;
            read_cnt      <= read_cnt + STEP_V;
            last_rd_addr  <= rd_burst_addr;
            rd_burst_addr <= rd_burst_addr + STEP_V;
            burst_len_err <= (beat_next != BURST_LEN_V);
            state         <= S_READ_BURST_END;
          end
        end
        S_READ_BURST_END: state <= req_d2 ? S_ACK : S_CHECK_FIFO;
        S_END:            state <= S_IDLE;
        default:          state <= S_IDLE;
      endcase
    end
  end

  // Beats outside a burst window (e.g. stragglers during a FIFO clear) are dropped.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      fifo_wr_en <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      fifo_wr_en <= (state == S_READ_BURST) && bus.rd_burst_data_valid;
      if ((state == S_READ_BURST) && bus.rd_burst_data_valid) fifo_wdata <= bus.rd_burst_data;
    end
  end

  assign bus.rd_burst_req  = rd_burst_req;
  assign bus.rd_burst_len  = rd_burst_len;
  assign bus.rd_burst_addr = rd_burst_addr;
  assign bus.read_req_ack  = read_req_ack;
  assign bus.read_finish   = (state == S_END);
  assign bus.fifo_aclr     = fifo_aclr;
  assign bus.fifo_wr_en    = fifo_wr_en;
  assign bus.fifo_wdata    = fifo_wdata;
  assign bus.burst_len_err = burst_len_err;
  assign bus.last_rd_addr  = last_rd_addr;
  assign bus.read_state    = state;

endmodule

// File: tb/tb_frame_burst_reader.sv
// Bench for frame_burst_reader: behavioural memory controller, expected-burst/beat queues checked by a negedge monitor.
module tb_frame_burst_reader;

  logic mem_clk = 1'b0;
  logic rst     = 1'b1;

  frame_burst_reader_if #(.MEM_DATA_BITS(32), .ADDR_BITS(23), .BURST_BITS(10)) bus ();

  frame_burst_reader dut (
    .mem_clk (mem_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 mem_clk = ~mem_clk;

  int total = 0;
  int bad   = 0;

  logic [22:0] exp_addr[$];
  logic [31:0] exp_data[$];

  int  beats_per_burst = 64;
  bit  ignore_wr       = 1'b0;
  int  wr_cnt = 0, burst_cnt = 0, fin_cnt = 0, fin_hi = 0;
  int  err_cnt = 0, err_hi = 0, aclr_cnt = 0, overlap = 0;
  bit  req_prev = 1'b0, fin_prev = 1'b0, err_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_burst(input logic [22:0] a, input int n);
    exp_addr.push_back(a);
    for (int i = 0; i < n; i++) exp_data.push_back({a, 9'(i)});
  endtask

  // Monitor / scoreboard
  always @(negedge mem_clk) begin
    if (bus.fifo_aclr) aclr_cnt++;
    if (bus.fifo_aclr && bus.fifo_wr_en) overlap++;
    if (bus.read_finish) fin_hi++;
    if (bus.read_finish && !fin_prev) fin_cnt++;
    if (bus.burst_len_err) err_hi++;
    if (bus.burst_len_err && !err_prev) err_cnt++;
    if (bus.rd_burst_req && !req_prev) begin
      burst_cnt++;
      if (exp_addr.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_burst actual=%0h required=none", bus.rd_burst_addr);
      end else begin
        chk("burst_addr", 32'(bus.rd_burst_addr), 32'(exp_addr.pop_front()));
        chk("burst_len", 32'(bus.rd_burst_len), 32'd64);
      end
    end
    if (bus.fifo_wr_en && !ignore_wr) begin
      wr_cnt++;
      if (exp_data.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_wr actual=%0h required=none", bus.fifo_wdata);
      end else begin
        chk("fifo_wdata", bus.fifo_wdata, exp_data.pop_front());
      end
    end
    req_prev = bus.rd_burst_req;
    fin_prev = bus.read_finish;
    err_prev = bus.burst_len_err;
  end

  // Behavioural controller: beats follow the request, then a separate finish pulse.
  initial begin
    logic [22:0] a;
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_data       = '0;
    bus.rd_burst_finish     = 1'b0;
    forever begin
      @(posedge mem_clk); #1;
      if (bus.rd_burst_req && !rst) begin
        a = bus.rd_burst_addr;
        for (int i = 0; i < beats_per_burst; i++) begin
          if (rst) break;
          bus.rd_burst_data_valid = 1'b1;
          bus.rd_burst_data       = {a, 9'(i)};
          @(posedge mem_clk); #1;
        end
        bus.rd_burst_data_valid = 1'b0;
        if (!rst) begin
          bus.rd_burst_finish = 1'b1;
          @(posedge mem_clk); #1;
          bus.rd_burst_finish = 1'b0;
        end
      end
    end
  end

  task automatic start_req(input logic [22:0] a, input logic [22:0] len);
    int c = 0;
    @(negedge mem_clk);
    bus.read_addr = a;
    bus.read_len  = len;
    bus.read_req  = 1'b1;
    while (bus.read_req_ack !== 1'b1 && c < 500) begin @(negedge mem_clk); c++; end
    chk("req_ack_seen", 32'(bus.read_req_ack), 32'd1);
    bus.read_req = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] st, input string nm);
    int c = 0;
    while (bus.read_state !== st && c < 500) begin @(negedge mem_clk); c++; end
    chk(nm, 32'(bus.read_state), 32'(st));
  endtask

  task automatic wait_fin(input int target, input string nm);
    int c = 0;
    while (fin_cnt < target && c < 2000) begin @(negedge mem_clk); c++; end
    chk(nm, fin_cnt, target);
  endtask

  initial begin
    int f0, fh0, b0, w0, a0, e0, eh0;
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, fh0, b0, w0, a0, e0, eh0;
    bus.read_req  = 1'b0;
    bus.read_addr = '0;
    bus.read_len  = '0;
    bus.wrusedw   = '0;

    // Reset state
    repeat (3) @(negedge mem_clk);
    chk("rst_state", 32'(bus.read_state), 32'd0);
    chk("rst_burst_req", 32'(bus.rd_burst_req), 32'd0);
    chk("rst_ack", 32'(bus.read_req_ack), 32'd0);
    chk("rst_aclr", 32'(bus.fifo_aclr), 32'd0);
    chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("rst_finish", 32'(bus.read_finish), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge mem_clk);

    // T1: two full bursts
    push_burst(23'h010000, 64);
    push_burst(23'h011000, 64);
    f0 = fin_cnt; fh0 = fin_hi; w0 = wr_cnt;
    start_req(23'h010000, 23'd8192);
    wait_fin(f0 + 1, "t1_finish");
    repeat (2) @(negedge mem_clk);
    chk("t1_wr_count", wr_cnt - w0, 128);
    chk("t1_finish_width", fin_hi - fh0, 1);
    chk("t1_last_addr", 32'(bus.last_rd_addr), 32'h011000);
    chk("t1_state_idle", 32'(bus.read_state), 32'd0);

    // T2: FIFO full holds off bursts; address wraps at the top of the space
    bus.wrusedw = 9'd200;
    push_burst(23'h7FF000, 64);
    push_burst(23'h000000, 64);
    f0 = fin_cnt;
    start_req(23'h7FF000, 23'd8192);
    wait_state(4'd2, "t2_reach_check");
    repeat (20) @(negedge mem_clk);
    chk("t2_stalled_state", 32'(bus.read_state), 32'd2);
    chk("t2_no_req", 32'(bus.rd_burst_req), 32'd0);
    bus.wrusedw = 9'd100;
    @(negedge mem_clk);
    chk("t2_req_next_cycle", 32'(bus.rd_burst_req), 32'd1);
    chk("t2_state_burst", 32'(bus.read_state), 32'd3);
    wait_fin(f0 + 1, "t2_finish");
    chk("t2_last_addr_wrap", 32'(bus.last_rd_addr), 32'h000000);
    bus.wrusedw = 9'd0;
    repeat (2) @(negedge mem_clk);

    // T3: zero length frame
    f0 = fin_cnt; fh0 = fin_hi; b0 = burst_cnt;
    start_req(23'h123000, 23'd0);
    wait_fin(f0 + 1, "t3_finish");
    repeat (3) @(negedge mem_clk);
    chk("t3_no_burst", burst_cnt - b0, 0);
    chk("t3_finish_width", fin_hi - fh0, 1);

    // T4: new request mid-burst waits for the burst, then relatches
    push_burst(23'h020000, 64);
    push_burst(23'h030000, 64);
    start_req(23'h020000, 23'd12288);
    wait_state(4'd3, "t4_in_burst");
    repeat (10) @(negedge mem_clk);
    a0 = aclr_cnt; f0 = fin_cnt; fh0 = fin_hi; b0 = burst_cnt;
    start_req(23'h030000, 23'd4096);
    wait_fin(f0 + 1, "t4_finish");
    repeat (2) @(negedge mem_clk);
    chk("t4_bursts_after", burst_cnt - b0, 1);
    chk("t4_aclr_pulsed", 32'(aclr_cnt > a0), 32'd1);
    chk("t4_last_addr", 32'(bus.last_rd_addr), 32'h030000);
    chk("t4_finish_width", fin_hi - fh0, 1);

    // T5: short bursts flag an error and the engine carries on
    beats_per_burst = 63;
    push_burst(23'h040000, 63);
    push_burst(23'h041000, 63);
    f0 = fin_cnt; e0 = err_cnt; eh0 = err_hi;
    start_req(23'h040000, 23'd8192);
    wait_fin(f0 + 1, "t5_finish");
    chk("t5_err_pulses", err_cnt - e0, 2);
    chk("t5_err_width", err_hi - eh0, 2);
    chk("t5_last_addr", 32'(bus.last_rd_addr), 32'h041000);
    beats_per_burst = 64;
    repeat (2) @(negedge mem_clk);

    // T6: reset mid-burst
    exp_addr.push_back(23'h050000);
    ignore_wr = 1'b1;
    start_req(23'h050000, 23'd8192);
    wait_state(4'd3, "t6_in_burst");
    repeat (5) @(negedge mem_clk);
    rst = 1'b1;
    #1;
    chk("t6_state", 32'(bus.read_state), 32'd0);
    chk("t6_burst_req", 32'(bus.rd_burst_req), 32'd0);
    chk("t6_burst_addr", 32'(bus.rd_burst_addr), 32'd0);
    chk("t6_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("t6_last_addr", 32'(bus.last_rd_addr), 32'd0);
    repeat (3) @(negedge mem_clk);
    rst = 1'b0;
    repeat (3) @(negedge mem_clk);
    ignore_wr = 1'b0;
    push_burst(23'h060000, 64);
    f0 = fin_cnt;
    start_req(23'h060000, 23'd4096);
    wait_fin(f0 + 1, "t6_restart_finish");
    chk("t6_restart_last", 32'(bus.last_rd_addr), 32'h060000);

    repeat (3) @(negedge mem_clk);
    chk("data_left", exp_data.size(), 0);
    chk("bursts_left", exp_addr.size(), 0);
    chk("aclr_wr_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
